// File: rtl/alu_mux_datapath.sv
// Execute/writeback slice: operand mux, add/sub ALU, writeback mux, plus a capture register.
// Define ALU_FLAGS_EN to add registered zero/negative/overflow flags.
module alu_mux_datapath #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sinal,
    input  logic             sinal_mux,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] dout_a,
    input  logic [WIDTH-1:0] dout_b,
    input  logic [WIDTH-1:0] dout_mem,
    output logic [WIDTH-1:0] s1,
    output logic [WIDTH-1:0] soma,
    output logic [WIDTH-1:0] s2,
    output logic [WIDTH-1:0] soma_q,
    output logic [WIDTH-1:0] s2_q
`ifdef ALU_FLAGS_EN
    ,
    output logic             zero_q,
    output logic             neg_q,
    output logic             ovf_q
`endif
);

    localparam int unsigned MSB = WIDTH - 1;

    logic [WIDTH-1:0] w_op_b;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] r_soma_q;
    logic [WIDTH-1:0] r_s2_q;

    // Subtract folds into the adder as a + ~b + 1; the carry-in is the op bit itself.
    always_comb begin
        s1     = sinal_mux ? dout_b : c;
        w_op_b = sinal ? ~s1 : s1;
        w_sum  = dout_a + w_op_b + WIDTH'(sinal);
        soma   = w_sum;
        s2     = sinal_mux ? w_sum : dout_mem;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_soma_q <= '0;
            r_s2_q   <= '0;
        end else if (en) begin
            r_soma_q <= w_sum;
            r_s2_q   <= s2;
        end
    end

    assign soma_q = r_soma_q;
    assign s2_q   = r_s2_q;

`ifdef ALU_FLAGS_EN
    logic w_zero;
    logic w_ovf;
    logic r_zero_q;
    logic r_neg_q;
    logic r_ovf_q;

    // Overflow on the effective adder operands covers both add and subtract cases.
    always_comb begin
        w_zero = (w_sum == '0);
        w_ovf  = (dout_a[MSB] == w_op_b[MSB]) && (w_sum[MSB] != dout_a[MSB]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero_q <= 1'b0;
            r_neg_q  <= 1'b0;
            r_ovf_q  <= 1'b0;
        end else if (en) begin
            r_zero_q <= w_zero;
            r_neg_q  <= w_sum[MSB];
            r_ovf_q  <= w_ovf;
        end
    end

    assign zero_q = r_zero_q;
    assign neg_q  = r_neg_q;
    assign ovf_q  = r_ovf_q;
`endif

endmodule

// File: tb/tb_alu_mux_datapath.sv
// Directed self-checking bench for alu_mux_datapath; flag checks build when ALU_FLAGS_EN is defined.
module tb_alu_mux_datapath;

    localparam int unsigned WIDTH = 64;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             sinal;
    logic             sinal_mux;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] dout_a;
    logic [WIDTH-1:0] dout_b;
    logic [WIDTH-1:0] dout_mem;
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] soma;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] soma_q;
    logic [WIDTH-1:0] s2_q;
`ifdef ALU_FLAGS_EN
    logic             zero_q;
    logic             neg_q;
    logic             ovf_q;
`endif

    int n_chk;
    int n_bad;

    alu_mux_datapath #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .sinal     (sinal),
        .sinal_mux (sinal_mux),
        .c         (c),
        .dout_a    (dout_a),
        .dout_b    (dout_b),
        .dout_mem  (dout_mem),
        .s1        (s1),
        .soma      (soma),
        .s2        (s2),
        .soma_q    (soma_q),
        .s2_q      (s2_q)
`ifdef ALU_FLAGS_EN
        ,
        .zero_q    (zero_q),
        .neg_q     (neg_q),
        .ovf_q     (ovf_q)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        en        = 1'b0;
        sinal     = 1'b0;
        sinal_mux = 1'b0;
        c         = '0;
        dout_a    = '0;
        dout_b    = '0;
        dout_mem  = '0;
        #2;
        chk("rst_soma_q", soma_q, 64'h0);
        chk("rst_s2_q",   s2_q,   64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // load address
        sinal_mux = 1'b0; sinal = 1'b0; c = 64'd1; dout_a = 64'd0; dout_mem = 64'h55;
        #1;
        chk("ld_s1",   s1,   64'd1);
        chk("ld_soma", soma, 64'd1);
        chk("ld_s2",   s2,   64'h55);
        en = 1'b1;
        edge_settle();
        chk("ld_soma_q", soma_q, 64'd1);
        chk("ld_s2_q",   s2_q,   64'h55);

        // register add
        sinal_mux = 1'b1; sinal = 1'b0; dout_a = 64'd7; dout_b = 64'd5;
        #1;
        chk("add_s1",   s1,   64'd5);
        chk("add_soma", soma, 64'd12);
        chk("add_s2",   s2,   64'd12);

        // register subtract, positive and negative result
        sinal = 1'b1; dout_a = 64'd12; dout_b = 64'd5;
        #1;
        chk("sub_pos", soma, 64'd7);
        dout_a = 64'd3;
        #1;
        chk("sub_neg", soma, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("sub_neg_s2", s2, 64'hFFFF_FFFF_FFFF_FFFE);

        // load with immediate subtract path (offset subtraction)
        sinal_mux = 1'b0; sinal = 1'b1; c = 64'd4; dout_a = 64'd20; dout_mem = 64'hABCD;
        #1;
        chk("ldsub_soma", soma, 64'd16);
        chk("ldsub_s2",   s2,   64'hABCD);

        // wrap-around
        sinal = 1'b0; sinal_mux = 1'b1; dout_a = 64'h7FFF_FFFF_FFFF_FFFF; dout_b = 64'd1;
        #1;
        chk("wrap_soma", soma, 64'h8000_0000_0000_0000);
        edge_settle();
        chk("wrap_soma_q", soma_q, 64'h8000_0000_0000_0000);
        chk("wrap_s2_q",   s2_q,   64'h8000_0000_0000_0000);
`ifdef ALU_FLAGS_EN
        chk("wrap_ovf",  WIDTH'(ovf_q),  64'd1);
        chk("wrap_neg",  WIDTH'(neg_q),  64'd1);
        chk("wrap_zero", WIDTH'(zero_q), 64'd0);
        // subtract overflow: min - 1
        sinal = 1'b1; dout_a = 64'h8000_0000_0000_0000; dout_b = 64'd1;
        edge_settle();
        chk("subovf_soma_q", soma_q, 64'h7FFF_FFFF_FFFF_FFFF);
        chk("subovf_ovf",  WIDTH'(ovf_q), 64'd1);
        chk("subovf_neg",  WIDTH'(neg_q), 64'd0);
        // zero result, no overflow
        dout_a = 64'd5; dout_b = 64'd5;
        edge_settle();
        chk("zero_zero", WIDTH'(zero_q), 64'd1);
        chk("zero_ovf",  WIDTH'(ovf_q),  64'd0);
        // restore the wrap-around capture for the hold check below
        sinal = 1'b0; dout_a = 64'h7FFF_FFFF_FFFF_FFFF; dout_b = 64'd1;
        edge_settle();
`endif

        // hold with en=0
        en = 1'b0;
        sinal = 1'b0; sinal_mux = 1'b0; c = 64'd9; dout_a = 64'd1; dout_mem = 64'h77;
        edge_settle();
        edge_settle();
        chk("hold_soma_q", soma_q, 64'h8000_0000_0000_0000);
        chk("hold_s2_q",   s2_q,   64'h8000_0000_0000_0000);

        // async reset pulse between edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_soma_q", soma_q, 64'h0);
        chk("arst_s2_q",   s2_q,   64'h0);
        chk("arst_comb",   soma,   64'd10);
        rst_n = 1'b1;
        en = 1'b1;
        sinal_mux = 1'b1; sinal = 1'b0; dout_a = 64'd7; dout_b = 64'd5;
        #1;
        chk("post_rst_hold", soma_q, 64'h0);
        edge_settle();
        chk("post_rst_soma_q", soma_q, 64'd12);
        chk("post_rst_s2_q",   s2_q,   64'd12);

        // unselected X inputs must not leak
        sinal_mux = 1'b1; sinal = 1'b0; dout_a = 64'd2; dout_b = 64'd3; dout_mem = 'x;
        #1;
        chk("xiso_s2_known", WIDTH'($isunknown(s2)), 64'd0);
        chk("xiso_s2",       s2, 64'd5);
        sinal_mux = 1'b0; dout_b = 'x; c = 64'd4; dout_a = 64'd10; dout_mem = 64'h1;
        #1;
        chk("xiso_soma_known", WIDTH'($isunknown(soma)), 64'd0);
        chk("xiso_soma", soma, 64'd14);
        chk("xiso_s1",   s1,   64'd4);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_mux_datapath.md
Name: alu_mux_datapath

Overview:
- Execute/writeback slice of the load/store/add/sub datapath.
- Operand mux selects immediate C or register port B. A 64-bit signed add/sub unit produces the result/memory address. A writeback mux selects memory data or the ALU result for the register-file write port.
- Combinational paths feed the register file and memory in the same cycle. A registered copy of the outputs (plus optional flags) is provided for pipelined consumers.

Parameters:
- WIDTH, 64, datapath width in bits; all data ports are WIDTH wide, two's-complement signed.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  capture enable for registered outputs
- sinal  in  1  ALU op: 0 = add, 1 = subtract
- sinal_mux  in  1  path select: 0 = load/store (immediate operand, memory writeback), 1 = register-register ALU op
- c  in  WIDTH  signed immediate/offset
- dout_a  in  WIDTH  register file port A data
- dout_b  in  WIDTH  register file port B data
- dout_mem  in  WIDTH  memory read data
- s1  out  WIDTH  selected second operand
- soma  out  WIDTH  ALU result; also the memory address
- s2  out  WIDTH  writeback data to register file din
- soma_q  out  WIDTH  registered soma
- s2_q  out  WIDTH  registered s2

Behaviour:
- Operand mux, combinational: s1 = sinal_mux ? dout_b : c.
- ALU, combinational: sinal=0 gives soma = dout_a + s1; sinal=1 gives soma = dout_a - s1.
  - Result is truncated to WIDTH bits; wrap-around is silent, no saturation.
  - Subtraction is implemented as dout_a + ~s1 + 1.
- Writeback mux, combinational: s2 = sinal_mux ? soma : dout_mem.
- All combinational outputs settle within the same cycle; no latency. Any X on an unselected mux input must not propagate.
- Registered stage:
  - rst_n low clears soma_q and s2_q to 0 asynchronously.
  - Otherwise, on a rising clk with en=1: soma_q <= soma, s2_q <= s2.
  - en=0 holds the current values.
- Reset deasserted mid-operation: the first capture happens on the first rising edge after release with en=1. Combinational outputs are unaffected by reset.
- Simultaneous change of sinal and sinal_mux: outputs reflect the new values combinationally. The register captures whatever is valid at the edge.
- No handshake and no state machine beyond the capture register.

Optional Feature:
- Macro ALU_FLAGS_EN.
- When defined, three extra outputs are present, each 1 bit, registered under the same en/reset rules as soma_q (reset value 0):
  - zero_q: soma == 0
  - neg_q: soma[WIDTH-1]
  - ovf_q: signed overflow
    - Add: operands have the same sign and the result sign differs.
    - Subtract: operands have different signs and the result sign differs from dout_a.
- When not defined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Load address: sinal_mux=0, sinal=0, c=1, dout_a=0, dout_mem=0x55 -> s1=1, soma=1, s2=0x55; after an en=1 edge, soma_q=1, s2_q=0x55.
- Register add: sinal_mux=1, sinal=0, dout_a=7, dout_b=5 -> s1=5, soma=12, s2=12.
- Register subtract: sinal_mux=1, sinal=1, dout_a=12, dout_b=5 -> soma=7. Then dout_a=3, dout_b=5 -> soma=-2 (0xFFFF_FFFF_FFFF_FFFE).
- Wrap-around: sinal=0, sinal_mux=1, dout_a=0x7FFF_FFFF_FFFF_FFFF, dout_b=1 -> soma=0x8000_0000_0000_0000. With ALU_FLAGS_EN, after an en=1 edge: ovf_q=1, neg_q=1, zero_q=0.
- Hold and reset: with en=0, change the inputs -> soma_q/s2_q unchanged. Pulse rst_n low between clock edges -> soma_q=s2_q=0 immediately; after release, the next en=1 edge captures the live values.
- X isolation: sinal_mux=1 with dout_mem=X -> s2 is fully defined. sinal_mux=0 with dout_b=X, c=4, dout_a=10 -> soma=14.
